// File: rtl/disp_scan_ctrl.sv
// Digit scan sequencer and frame-synchronous display word owner for the seven-segment stage.
// Optional macro SCAN_FREEZE_EN adds a freeze input that blocks word updates and head/tail swaps.
module disp_scan_ctrl #(
    parameter int SCAN_TICKS  = 50000,
    parameter int SWAP_FRAMES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] num_in,
    input  logic        num_valid,
    output logic        num_ready,
    input  logic        auto_swap,
    input  logic        half_sel,
    input  logic        graph,
`ifdef SCAN_FREEZE_EN
    input  logic        freeze,
`endif
    output logic [31:0] disp_num,
    output logic [1:0]  SW,
    output logic [1:0]  Scanning,
    output logic        frame_tick
);

    localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int FW = (SWAP_FRAMES > 1) ? $clog2(SWAP_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_TICKS - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(SWAP_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic [FW-1:0] frm_cnt;
    logic          half;
    logic          graph_q;
    logic          digit_tick;
    logic          frame_end;
    logic          hold;

`ifdef SCAN_FREEZE_EN
    assign hold = freeze;
`else
    assign hold = 1'b0;
`endif

    assign digit_tick = (cnt == CNT_MAX);
    assign frame_end  = digit_tick && (Scanning == 2'd3);
    // NOTE: num_ready is combinational so the accept lands on the same edge Scanning wraps to 0.
    assign num_ready  = frame_end && !hold;
    assign SW         = {half, graph_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            Scanning   <= 2'd0;
            frame_tick <= 1'b0;
            disp_num   <= 32'd0;
            frm_cnt    <= '0;
            half       <= 1'b0;
            graph_q    <= 1'b0;
        end else begin
            cnt        <= digit_tick ? '0 : cnt + 1'b1;
            frame_tick <= frame_end;
            graph_q    <= graph;
            if (digit_tick)
                Scanning <= Scanning + 2'd1;
            if (num_valid && num_ready)
                disp_num <= num_in;
            // Manual mode parks the frame counter so auto mode always starts counting from 0.
            if (!auto_swap) begin
                half    <= half_sel;
                frm_cnt <= '0;
            end else if (frame_end && !hold) begin
                if (frm_cnt == FRM_MAX) begin
                    half    <= ~half;
                    frm_cnt <= '0;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_TICKS=4, SWAP_FRAMES=2 (frame = 16 cycles).
// cyc counts rising edges since reset release; checks are made 1 time unit after each edge.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] num_in = 32'd0;
    logic        num_valid = 1'b0;
    logic        num_ready;
    logic        auto_swap = 1'b0;
    logic        half_sel = 1'b0;
    logic        graph = 1'b0;
`ifdef SCAN_FREEZE_EN
    logic        freeze = 1'b0;
`endif
    logic [31:0] disp_num;
    logic [1:0]  SW;
    logic [1:0]  Scanning;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    disp_scan_ctrl #(.SCAN_TICKS(4), .SWAP_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .num_in(num_in), .num_valid(num_valid),
        .num_ready(num_ready), .auto_swap(auto_swap), .half_sel(half_sel),
        .graph(graph),
`ifdef SCAN_FREEZE_EN
        .freeze(freeze),
`endif
        .disp_num(disp_num), .SW(SW), .Scanning(Scanning), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (disp_num !== 32'd0 || SW !== 2'b00 || Scanning !== 2'd0 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: disp_num=%h SW=%b Scanning=%0d frame_tick=%b, want 0/00/0/0",
                     disp_num, SW, Scanning, frame_tick);
        end
        checks++;
        if (num_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: num_ready=%b want 0", num_ready);
        end
    endtask

    task automatic test_scan();
        logic [1:0] exp_scan;
        logic       exp_tick;
        do_reset();
        for (int n = 1; n <= 36; n++) begin
            tick();
            exp_scan = 2'((n / 4) % 4);
            exp_tick = (n % 16 == 0);
            checks++;
            if (Scanning !== exp_scan || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL scan cyc=%0d: Scanning=%0d frame_tick=%b want %0d/%b",
                         n, Scanning, frame_tick, exp_scan, exp_tick);
            end
        end
    endtask

    task automatic test_update();
        logic [31:0] exp_num;
        do_reset();
        num_in = 32'h12345678;
        while (cyc < 4) tick();
        num_valid = 1'b1;
        for (int n = 5; n <= 16; n++) begin
            tick();
            exp_num = (n >= 16) ? 32'h12345678 : 32'd0;
            checks++;
            if (num_ready !== (n == 15) || disp_num !== exp_num) begin
                errors++;
                $display("FAIL update cyc=%0d: num_ready=%b disp_num=%h want %b/%h",
                         n, num_ready, disp_num, (n == 15), exp_num);
            end
        end
        num_valid = 1'b0;
        // Offer withdrawn before the next frame end: no update.
        while (cyc < 20) tick();
        num_in = 32'hAABBCCDD;
        num_valid = 1'b1;
        while (cyc < 28) tick();
        num_valid = 1'b0;
        while (cyc < 32) tick();
        checks++;
        if (disp_num !== 32'h12345678) begin
            errors++;
            $display("FAIL update_dropped: disp_num=%h want 12345678", disp_num);
        end
    endtask

    task automatic test_auto_swap();
        logic exp_half;
        logic [31:0] exp_num;
        auto_swap = 1'b1;
        half_sel = 1'b0;
        num_valid = 1'b0;
        do_reset();
        for (int n = 1; n <= 66; n++) begin
            if (n == 20) begin
                num_in = 32'hCAFEF00D;
                num_valid = 1'b1;
            end
            half_sel = ~half_sel;
            tick();
            exp_half = (n >= 32 && n < 64);
            exp_num = (n >= 32) ? 32'hCAFEF00D : 32'd0;
            checks++;
            if (SW[1] !== exp_half || disp_num !== exp_num) begin
                errors++;
                $display("FAIL auto_swap cyc=%0d: SW[1]=%b disp_num=%h want %b/%h",
                         n, SW[1], disp_num, exp_half, exp_num);
            end
        end
        num_valid = 1'b0;
        auto_swap = 1'b0;
        half_sel = 1'b0;
    endtask

    task automatic test_manual_to_auto();
        do_reset();
        tick();
        tick();
        half_sel = 1'b1;
        graph = 1'b1;
        checks++;
        if (SW !== 2'b00) begin
            errors++;
            $display("FAIL manual_latency: SW=%b want 00", SW);
        end
        tick();
        checks++;
        if (SW !== 2'b11) begin
            errors++;
            $display("FAIL manual_select: SW=%b want 11", SW);
        end
        auto_swap = 1'b1;
        half_sel = 1'b0;
        for (int n = 4; n <= 32; n++) begin
            tick();
            checks++;
            if (SW[1] !== (n < 32)) begin
                errors++;
                $display("FAIL enter_auto cyc=%0d: SW[1]=%b want %b", n, SW[1], (n < 32));
            end
        end
        auto_swap = 1'b0;
        half_sel = 1'b1;
        tick();
        checks++;
        if (SW !== 2'b11) begin
            errors++;
            $display("FAIL leave_auto: SW=%b want 11", SW);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        num_in = 32'hDEADBEEF;
        num_valid = 1'b1;
        half_sel = 1'b1;
        graph = 1'b1;
        while (cyc < 24) tick();
        checks++;
        if (disp_num !== 32'hDEADBEEF || Scanning !== 2'd2 || SW !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset: disp_num=%h Scanning=%0d SW=%b want deadbeef/2/11",
                     disp_num, Scanning, SW);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (disp_num !== 32'd0 || Scanning !== 2'd0 || SW !== 2'b00 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: disp_num=%h Scanning=%0d SW=%b frame_tick=%b want 0",
                     disp_num, Scanning, SW, frame_tick);
        end
        num_valid = 1'b0;
        half_sel = 1'b0;
        graph = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if (Scanning !== 2'(n / 4)) begin
                errors++;
                $display("FAIL restart_dwell cyc=%0d: Scanning=%0d want %0d", n, Scanning, n / 4);
            end
        end
    endtask

`ifdef SCAN_FREEZE_EN
    task automatic test_freeze();
        auto_swap = 1'b1;
        num_in = 32'h55AA33CC;
        num_valid = 1'b1;
        freeze = 1'b1;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            tick();
            checks++;
            if (num_ready !== 1'b0 || disp_num !== 32'd0 || SW[1] !== 1'b0 ||
                frame_tick !== (n % 16 == 0)) begin
                errors++;
                $display("FAIL freeze cyc=%0d: num_ready=%b disp_num=%h SW[1]=%b frame_tick=%b",
                         n, num_ready, disp_num, SW[1], frame_tick);
            end
        end
        freeze = 1'b0;
        while (cyc < 47) tick();
        checks++;
        if (num_ready !== 1'b1) begin
            errors++;
            $display("FAIL unfreeze_ready: num_ready=%b want 1", num_ready);
        end
        tick();
        checks++;
        if (disp_num !== 32'h55AA33CC || SW[1] !== 1'b0) begin
            errors++;
            $display("FAIL unfreeze_load: disp_num=%h SW[1]=%b want 55aa33cc/0", disp_num, SW[1]);
        end
        num_valid = 1'b0;
        auto_swap = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_update();
        test_auto_swap();
        test_manual_to_auto();
        test_async_reset();
`ifdef SCAN_FREEZE_EN
        test_freeze();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
